fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction emitted on bubble or flush.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is the system's job.
REQ-005 SHALL have port PCWrite  input  1  1 permits issuing new fetch requests; 0 holds fetch PC (load-use stall).
REQ-006 SHALL have port FetchWrite  input  1  1 permits IF/ID output register update; 0 holds it.
REQ-007 SHALL have port PCSrc  input  1  branch taken; redirect to pc_branch.
REQ-008 SHALL have port pc_branch  input  32  redirect target.
REQ-009 SHALL have port imem_req  output  1  fetch request valid.
REQ-010 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-011 SHALL have port imem_ready  input  1  memory accepts request; transfer when imem_req && imem_ready.
REQ-012 SHALL have port imem_rvalid  input  1  response valid, in request order, max one per cycle.
REQ-013 SHALL have port imem_rdata  input  32  response instruction word.
REQ-014 SHALL have port instruction  output  32  IF/ID instruction to decode.
REQ-015 SHALL have port pc  output  32  IF/ID address of instruction.
REQ-016 SHALL have port valid  output  1  IF/ID holds a real fetched instruction.

Function
REQ-017 SHALL keep fetch_pc (32b), outstanding counter (0..2), drop counter (0..2), 2-entry FIFO of {instr,pc}, and state in {BOOT, RUN, DRAIN}.
REQ-018 SHALL drive imem_addr = fetch_pc; imem_req = 1 only in RUN/DRAIN, PCWrite=1, PCSrc=0, and outstanding + FIFO count < 2 (registered values, no same-cycle credit).
REQ-019 SHALL on accepted request increment outstanding and set fetch_pc = fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-020 SHALL on imem_rvalid decrement outstanding; if drop counter > 0, discard the word and decrement drop counter, else tag it with its request address and deliver it.
REQ-021 SHALL on FetchWrite=1 and PCSrc=0 load IF/ID from FIFO head if non-empty, else directly from a same-cycle delivered response (bypass), else NOP_INSTR with valid=0 and pc unchanged.
REQ-022 SHALL write a delivered response to FIFO when not consumed by IF/ID the same cycle; FIFO never overflows by REQ-018.
REQ-023 SHALL on FetchWrite=0 and PCSrc=0 hold instruction, pc, valid unchanged.
REQ-024 SHALL on PCSrc=1 (priority over PCWrite/FetchWrite): fetch_pc <= pc_branch; FIFO emptied; IF/ID <= NOP_INSTR, valid=0; drop counter <= outstanding after this cycle's response; no request issued this cycle.
REQ-025 SHALL transition BOOT->RUN one cycle after reset release; RUN->DRAIN on PCSrc with nonzero new drop count; DRAIN->RUN when drop counter reaches 0; PCSrc in DRAIN reloads drop count.
REQ-026 SHALL allow new requests in DRAIN; their responses follow dropped ones and are delivered normally.
REQ-027 SHALL ignore pc_branch bits [1:0] (force to 0).

Reset
REQ-028 SHALL on rst=0 immediately set fetch_pc=RESET_PC, counters=0, FIFO empty, state=BOOT, instruction=NOP_INSTR, pc=RESET_PC, valid=0, imem_req=0.
REQ-029 SHALL treat reset mid-transaction as abandoning all outstanding requests; responses arriving after release while outstanding=0 SHALL be ignored.

Verification
REQ-030 Reset release, ready=1, 1-cycle latency memory -> addr 0,4,8 issued back-to-back; IF/ID valid with pc 0 two cycles after first request; one instruction per cycle thereafter.
REQ-031 FetchWrite=0 for 3 cycles while streaming -> IF/ID frozen, FIFO fills to 2, imem_req drops; on release, instructions continue in order with no loss or duplicate.
REQ-032 PCSrc=1, pc_branch=0x100 with 2 outstanding -> IF/ID NOP valid=0 next cycle; both stale responses discarded; next valid pc = 0x100.
REQ-033 PCSrc asserted concurrently with PCWrite=0 and FetchWrite=0 -> redirect still taken, flush occurs.
REQ-034 fetch_pc=0xFFFF_FFFC accepted -> next imem_addr = 0x0000_0000.
REQ-035 rst asserted with 2 outstanding, stray rvalid after release -> ignored; first valid pc = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch with a 2-entry response FIFO,
// load-use stall, IF/ID hold and branch flush with stale-response dropping.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        FetchWrite,
  input  logic        PCSrc,
  input  logic [31:0] pc_branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid
);
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding, drop, fcnt, out_nx, drop_nx;
  logic [31:0] req_pc [2];
  logic [63:0] fifo [2];
  logic        fire, rv, deliver, take, pop, bypass, push, rslot, fslot;
  always_comb begin
    imem_addr = fetch_pc;
    imem_req  = state != BOOT && PCWrite && !PCSrc && ({1'b0, outstanding} + {1'b0, fcnt}) < 3'd2;
    fire      = imem_req && imem_ready;
    // responses with nothing outstanding are leftovers from before a reset
    rv        = imem_rvalid && outstanding != 2'd0;
    deliver   = rv && drop == 2'd0;
    take      = FetchWrite && !PCSrc;
    pop       = take && fcnt != 2'd0;
    bypass    = take && fcnt == 2'd0 && deliver;
    push      = deliver && !PCSrc && !bypass;
    rslot     = outstanding[1] | (outstanding[0] & !rv);
    fslot     = fcnt[1] | (fcnt[0] & !pop);
    out_nx    = outstanding + {1'b0, fire} - {1'b0, rv};
    drop_nx   = PCSrc ? out_nx : drop - {1'b0, rv && drop != 2'd0};
    state_nx  = state == BOOT ? RUN : (drop_nx != 2'd0 ? DRAIN : RUN);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      fcnt        <= 2'd0;
      req_pc[0]   <= '0;
      req_pc[1]   <= '0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
      instruction <= NOP_INSTR;
      pc          <= RESET_PC;
      valid       <= 1'b0;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;
      drop        <= drop_nx;
      fetch_pc    <= PCSrc ? (pc_branch & 32'hFFFF_FFFC) : fetch_pc + (fire ? 32'd4 : 32'd0);
      if (rv) req_pc[0] <= req_pc[1];
      if (fire) req_pc[rslot] <= fetch_pc;
      fcnt <= PCSrc ? 2'd0 : fcnt - {1'b0, pop} + {1'b0, push};
      if (pop) fifo[0] <= fifo[1];
      if (push) fifo[fslot] <= {imem_rdata, req_pc[0]};
      if (PCSrc) begin
        instruction <= NOP_INSTR;
        valid       <= 1'b0;
      end else if (FetchWrite) begin
        instruction <= pop ? fifo[0][63:32] : bypass ? imem_rdata : NOP_INSTR;
        pc          <= pop ? fifo[0][31:0] : bypass ? req_pc[0] : pc;
        valid       <= pop || bypass;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized stimulus checked against a queue-based
// reference model of the fetch stage and an in-order variable-latency memory.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 0, PCWrite = 0, FetchWrite = 0, PCSrc = 0;
  logic imem_ready = 0, imem_rvalid = 0, imem_req, valid;
  logic [31:0] pc_branch = 0, imem_rdata = 0, imem_addr, instruction, pc;
  int checks = 0, errors = 0, cyc = 0, lat = 1;
  bit stray = 0;
  typedef struct {logic [31:0] a; int t;} mreq_t;
  mreq_t mq[$];
  logic [31:0] oq[$];
  logic [63:0] fq[$];
  logic [31:0] m_fpc, m_instr, m_pc;
  bit m_valid, m_boot;
  int m_drop;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .FetchWrite(FetchWrite), .PCSrc(PCSrc),
    .pc_branch(pc_branch), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .valid(valid)
  );

  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 0;
    imem_rvalid = 0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_instr", instruction, NOP);
    chk("rst_pc", pc, RPC);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    mq.delete(); oq.delete(); fq.delete();
    m_fpc = RPC; m_instr = NOP; m_pc = RPC; m_valid = 0; m_boot = 1; m_drop = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic cycle();
    bit m_req, fire, dlv;
    logic [31:0] a, d_i, d_p;
    if (stray) begin
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; stray = 0;
    end else if (mq.size() > 0 && mq[0].t <= cyc) begin
      imem_rvalid = 1; imem_rdata = word(mq[0].a); void'(mq.pop_front());
    end else begin
      imem_rvalid = 0; imem_rdata = $urandom;
    end
    @(negedge clk);
    m_req = !m_boot && PCWrite && !PCSrc && (oq.size() + fq.size() < 2);
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("imem_addr", imem_addr, m_fpc);
    chk("instruction", instruction, m_instr);
    chk("pc", pc, m_pc);
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    fire = m_req && imem_ready;
    if (fire) mq.push_back('{a: m_fpc, t: cyc + lat});
    dlv = 0; d_i = 0; d_p = 0;
    if (imem_rvalid && oq.size() > 0) begin
      a = oq.pop_front();
      if (m_drop > 0) m_drop--;
      else begin dlv = 1; d_i = imem_rdata; d_p = a; end
    end
    if (PCSrc) begin
      m_fpc = pc_branch & ~32'h3; fq.delete(); m_instr = NOP; m_valid = 0; m_drop = oq.size();
    end else begin
      if (fire) begin oq.push_back(m_fpc); m_fpc += 4; end
      if (FetchWrite && fq.size() > 0) begin
        {m_instr, m_pc} = fq.pop_front(); m_valid = 1;
      end else if (FetchWrite && dlv) begin
        m_instr = d_i; m_pc = d_p; m_valid = 1; dlv = 0;
      end else if (FetchWrite) begin
        m_instr = NOP; m_valid = 0;
      end
      if (dlv) fq.push_back({d_i, d_p});
    end
    m_boot = 0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic first_valid(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!valid && n < 30) begin cycle(); n++; end
    chk({tag, "_valid"}, {31'b0, valid}, 32'd1);
    chk({tag, "_pc"}, pc, exp);
  endtask

  task automatic wait_two_out(input string tag);
    int n = 0;
    while (oq.size() != 2 && n < 30) begin cycle(); n++; end
    if (oq.size() != 2) begin
      checks++; errors++;
      $error("FAIL %s observed %0d outstanding expected 2", tag, oq.size());
    end
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    PCWrite = 1; FetchWrite = 1; imem_ready = 1; lat = 1;
    run(3);
    chk("req030_valid", {31'b0, valid}, 32'd1);
    chk("req030_pc0", pc, 32'h0);
    cycle();
    chk("req030_pc4", pc, 32'h4);
    run(4);
    FetchWrite = 0;
    run(3);
    chk("req031_req_drop", {31'b0, imem_req}, 32'd0);
    chk("req031_frozen", {31'b0, valid}, 32'd1);
    FetchWrite = 1;
    run(8);
    lat = 2;
    wait_two_out("req032_setup");
    PCSrc = 1; pc_branch = 32'h100;
    cycle();
    PCSrc = 0;
    chk("req032_nop", instruction, NOP);
    chk("req032_inv", {31'b0, valid}, 32'd0);
    first_valid("req032", 32'h100);
    run(3);
    lat = 1;
    PCWrite = 0; FetchWrite = 0; PCSrc = 1; pc_branch = 32'h203;
    cycle();
    PCSrc = 0; PCWrite = 1; FetchWrite = 1;
    chk("req033_inv", {31'b0, valid}, 32'd0);
    chk("req033_addr", imem_addr, 32'h200);
    first_valid("req033", 32'h200);
    PCWrite = 0;
    run(3);
    PCWrite = 1; PCSrc = 1; pc_branch = 32'hFFFF_FFFF;
    cycle();
    PCSrc = 0;
    chk("req034_pre", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("req034_wrap", imem_addr, 32'h0);
    first_valid("req034", 32'hFFFF_FFFC);
    run(2);
    lat = 3;
    wait_two_out("req035_setup");
    do_reset();
    stray = 1; lat = 1;
    first_valid("req035", RPC);
    for (int i = 0; i < 500; i++) begin
      PCWrite    = $urandom_range(0, 9) != 0;
      FetchWrite = $urandom_range(0, 4) != 0;
      PCSrc      = $urandom_range(0, 11) == 0;
      pc_branch  = $urandom;
      imem_ready = $urandom_range(0, 3) != 0;
      lat        = $urandom_range(1, 3);
      cycle();
    end
    PCSrc = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
